// File: rtl/seq_encoder_8x3.sv
// seq_encoder_8x3: valid/ready 8-to-3 encoder emitting each set-bit index of an accepted vector in priority order
module seq_encoder_8x3 #(
  parameter int PRIORITY_MSB = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] D,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] A,
  output logic       last,
  output logic       zero,
  output logic [3:0] count
);
  typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;
  state_t state, state_n;
  logic [7:0] pend, pend_n;
  logic [3:0] count_n;
  // priority encoder over the pending bits; the last hit in scan order is the winner
  always_comb begin
    A = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (PRIORITY_MSB != 0 && pend[i]) A = 3'(i);
      if (PRIORITY_MSB == 0 && pend[7-i]) A = 3'(7 - i);
    end
  end
  // handshake decode, output flags and next-state; pend is empty in IDLE/ZERO so A reads 0 there
  always_comb begin
    state_n = state;
    pend_n = pend;
    count_n = count;
    in_ready = state == IDLE && E && !rst;
    out_valid = state != IDLE;
    zero = state == ZERO;
    last = zero || (pend != 8'd0 && (pend & (pend - 8'd1)) == 8'd0);
    if (in_valid && in_ready) begin
      pend_n = D;
      count_n = 4'($countones(D));
      state_n = D == 8'd0 ? ZERO : SCAN;
    end
    if (out_valid && out_ready) begin
      pend_n = pend & ~(8'd1 << A);
      state_n = last ? IDLE : state;
    end
  end
  // state, pending vector and latched popcount
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend <= 8'd0;
      count <= 4'd0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      count <= count_n;
    end
  end
endmodule

// File: tb/tb_seq_encoder_8x3.sv
// tb_seq_encoder_8x3: MSB- and LSB-priority encoders driven in lockstep against a queue-based model
module tb_seq_encoder_8x3;
  typedef struct packed {
    logic [2:0] a;
    logic       last;
    logic       zero;
    logic [3:0] count;
  } rec_t;
  logic clk = 1'b0;
  logic rst, e, in_valid, out_ready;
  logic [7:0] d;
  logic [1:0] in_ready, out_valid, last, zero;
  logic [2:0] a [2];
  logic [3:0] cnt [2];
  int pass_n = 0;
  int total_n = 0;
  logic [31:0] s0, s1;
  int n;
  logic [3:0] c0;
  logic z0;
  always #5 clk = ~clk;
  seq_encoder_8x3 #(.PRIORITY_MSB(1)) u_msb (
    .clk(clk), .rst(rst), .E(e), .in_valid(in_valid), .in_ready(in_ready[0]), .D(d),
    .out_valid(out_valid[0]), .out_ready(out_ready), .A(a[0]), .last(last[0]),
    .zero(zero[0]), .count(cnt[0])
  );
  seq_encoder_8x3 #(.PRIORITY_MSB(0)) u_lsb (
    .clk(clk), .rst(rst), .E(e), .in_valid(in_valid), .in_ready(in_ready[1]), .D(d),
    .out_valid(out_valid[1]), .out_ready(out_ready), .A(a[1]), .last(last[1]),
    .zero(zero[1]), .count(cnt[1])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // model: an accepted vector expands into its list of index records; each output handshake pops one
  for (genvar k = 0; k < 2; k++) begin : g_model
    rec_t q [$];
    rec_t r;
    int pc;
    always @(posedge clk) begin
      if (rst) q.delete();
      else if (out_ready && q.size() > 0) r = q.pop_front();
      else if (in_valid && e && q.size() == 0) begin
        pc = $countones(d);
        if (d == 8'h00) q.push_back('{3'd0, 1'b1, 1'b1, 4'd0});
        else begin
          for (int j = 0; j < 8; j++)
            if (d[k == 0 ? 7 - j : j]) q.push_back('{3'(k == 0 ? 7 - j : j), 1'b0, 1'b0, 4'(pc)});
          r = q.pop_back();
          r.last = 1'b1;
          q.push_back(r);
        end
      end
    end
    always @(negedge clk) begin
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(!rst && e && q.size() == 0));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(q.size() != 0));
      if (q.size() != 0)
        chk($sformatf("a_last_zero_count[%0d]", k), 32'({a[k], last[k], zero[k], cnt[k]}), 32'(q[0]));
    end
  end
  task automatic tick(input int c = 1);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [7:0] v, input logic [3:0] pat, input logic e_after,
                     output logic [31:0] r0, output logic [31:0] r1, output int cnt_hs,
                     output logic [3:0] first_count, output logic first_zero);
    d = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = e_after;
    r0 = 32'd0;
    r1 = 32'd0;
    cnt_hs = 0;
    first_count = 4'd0;
    first_zero = 1'b0;
    for (int c = 0; c < 60; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (c == 0) begin
        chk("first out_valid", 32'(out_valid), 32'd3);
        first_count = cnt[0];
        first_zero = zero[0];
      end
      if (out_valid == 2'b00) break;
      if (out_ready) begin
        r0 = {r0[27:0], 1'b0, a[0]};
        r1 = {r1[27:0], 1'b0, a[1]};
        cnt_hs++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    e = 1'b1;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    e = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    d = 8'h00;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset A", 32'({a[0], a[1]}), 32'd0);
    chk("reset count", 32'({cnt[0], cnt[1]}), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd3);
    tick();
    for (int i = 0; i < 8; i++) begin
      run(8'(1 << i), 4'hF, 1'b1, s0, s1, n, c0, z0);
      chk($sformatf("onehot %0d msb A", i), s0, 32'(i));
      chk($sformatf("onehot %0d lsb A", i), s1, 32'(i));
      chk($sformatf("onehot %0d handshakes", i), 32'(n), 32'd1);
      chk($sformatf("onehot %0d count", i), 32'(c0), 32'd1);
    end
    run(8'b1010_0110, 4'hF, 1'b1, s0, s1, n, c0, z0);
    chk("multihot msb order", s0, 32'h7521);
    chk("multihot lsb order", s1, 32'h1257);
    chk("multihot handshakes", 32'(n), 32'd4);
    chk("multihot count", 32'(c0), 32'd4);
    run(8'hFF, 4'b1001, 1'b1, s0, s1, n, c0, z0);
    chk("backpressure msb order", s0, 32'h76543210);
    chk("backpressure lsb order", s1, 32'h01234567);
    chk("backpressure handshakes", 32'(n), 32'd8);
    chk("backpressure count", 32'(c0), 32'd8);
    run(8'h00, 4'hF, 1'b1, s0, s1, n, c0, z0);
    chk("zero handshakes", 32'(n), 32'd1);
    chk("zero A", s0 | s1, 32'd0);
    chk("zero flag", 32'(z0), 32'd1);
    chk("zero count", 32'(c0), 32'd0);
    e = 1'b0;
    d = 8'h10;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("E=0 in_ready", 32'(in_ready), 32'd0);
      chk("E=0 out_valid", 32'(out_valid), 32'd0);
    end
    e = 1'b1;
    run(8'h10, 4'hF, 1'b1, s0, s1, n, c0, z0);
    chk("enable A", {s0[15:0], s1[15:0]}, 32'h0004_0004);
    chk("enable handshakes", 32'(n), 32'd1);
    run(8'h03, 4'hF, 1'b0, s0, s1, n, c0, z0);
    chk("E drop msb order", s0, 32'h10);
    chk("E drop lsb order", s1, 32'h01);
    chk("E drop handshakes", 32'(n), 32'd2);
    d = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("midscan reset out_valid", 32'(out_valid), 32'd0);
    chk("midscan reset A", 32'({a[0], a[1]}), 32'd0);
    chk("midscan reset count", 32'({cnt[0], cnt[1]}), 32'd0);
    chk("midscan reset in_ready", 32'(in_ready), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post reset silent", 32'(out_valid), 32'd0);
    end
    tick(2);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
